// File: rtl/responderGroup.sv
// Shared types for the bus responder: access sizes and FSM states.
package responderGroup;

    // Encoding matches the reqSize input field.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } accessSize;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } responderState;

    // Width of the wait-state counter (WAIT_STATES is limited to 0..15).
    localparam int unsigned WaitWidth = 4;

endpackage

// File: rtl/lane_steer.sv
// Combinational byte-lane steering: byte enables, store-data replication,
// alignment check and load-data extraction with zero/sign extension.
module lane_steer
    import responderGroup::*;
(
    input  accessSize   i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte_lane;
    logic [15:0] w_half_lane;

    assign w_byte_lane = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half_lane = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Decode the access size into lanes, store replication and load extension.
    // o_misaligned also covers the reserved size so the caller needs one error flag.
    always_comb begin
        o_byte_en    = 4'b0000;
        o_wdata      = 32'h0;
        o_misaligned = 1'b0;
        o_rdata      = 32'h0;
        unique case (i_size)
            BYTE: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = {{24{i_signed & w_byte_lane[7]}}, w_byte_lane};
            end
            HALF: begin
                o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
                o_rdata      = {{16{i_signed & w_half_lane[15]}}, w_half_lane};
            end
            WORD: begin
                o_byte_en    = 4'b1111;
                o_wdata      = i_wdata;
                o_misaligned = |i_addr_lo;
                o_rdata      = i_rdata;
            end
            RSVD: begin
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bus_responder.sv
// CPU-to-SRAM bus responder: accepts one request at a time, performs a
// wait-stated SRAM access, then holds the response until the CPU takes it.
module bus_responder
    import responderGroup::*;
#(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respError,
    output logic [29:0] memAddress,
    output logic        memReadEn,
    output logic        memWriteEn,
    output logic [3:0]  memByteEn,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    responderState        r_state;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_respData;
    accessSize            r_size;
    logic                 r_write;
    logic                 r_signed;
    logic                 r_respError;
    logic [WaitWidth-1:0] r_wait;

    accessSize            w_size;
    logic [1:0]           w_addr_lo;
    logic [3:0]           w_byte_en;
    logic [31:0]          w_wdata_lanes;
    logic [31:0]          w_rdata_ext;
    logic                 w_misaligned;
    logic                 w_in_access;
    logic                 w_last;

    // In IDLE the steering logic looks at the live request so the alignment
    // check is ready at the acceptance edge; afterwards it uses the latched one.
    assign w_size    = (r_state == IDLE) ? accessSize'(reqSize) : r_size;
    assign w_addr_lo = (r_state == IDLE) ? address[1:0] : r_addr[1:0];

    lane_steer u_lane_steer (
        .i_size       (w_size),
        .i_signed     (r_signed),
        .i_addr_lo    (w_addr_lo),
        .i_wdata      (r_wdata),
        .i_rdata      (memReadData),
        .o_byte_en    (w_byte_en),
        .o_wdata      (w_wdata_lanes),
        .o_misaligned (w_misaligned),
        .o_rdata      (w_rdata_ext)
    );

    assign w_in_access = (r_state == ACCESS);
    assign w_last      = (r_wait == '0);

    // Request FSM: latch on accept, count wait states, hold response until taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_respData  <= 32'h0;
            r_size      <= BYTE;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_respError <= 1'b0;
            r_wait      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reqValid) begin
                        r_addr     <= address;
                        r_size     <= accessSize'(reqSize);
                        r_write    <= reqWrite;
                        r_signed   <= reqSigned;
                        r_wdata    <= writeData;
                        r_respData <= 32'h0;
                        if (w_misaligned) begin
                            r_state     <= RESPOND;
                            r_respError <= 1'b1;
                            r_wait      <= '0;
                        end else begin
                            r_state     <= ACCESS;
                            r_respError <= 1'b0;
                            r_wait      <= WaitWidth'(WAIT_STATES);
                        end
                    end
                end
                ACCESS: begin
                    if (w_last) begin
                        r_state    <= RESPOND;
                        r_respData <= r_write ? 32'h0 : w_rdata_ext;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                RESPOND: begin
                    if (respReady) begin
                        r_state     <= IDLE;
                        r_respData  <= 32'h0;
                        r_respError <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign reqReady     = (r_state == IDLE);
    assign respValid    = (r_state == RESPOND);
    assign respData     = r_respData;
    assign respError    = r_respError;
    assign memAddress   = r_addr[31:2];
    assign memReadEn    = w_in_access & ~r_write;
    // Strobe derives from state, so asynchronous reset kills it immediately.
    assign memWriteEn   = w_in_access & r_write & w_last;
    assign memByteEn    = w_in_access ? w_byte_en : 4'b0000;
    assign memWriteData = w_in_access ? w_wdata_lanes : 32'h0;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed requests, a behavioural
// model of the expected bus timeline, and literal expectations per vector.
module tb_bus_responder;

    localparam int unsigned W = 2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          hold;
        logic        early;
        logic [31:0] x_data;
        logic        x_err;
        logic [3:0]  x_be;
        logic [31:0] x_wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqSigned = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] writeData = 32'h0;
    logic        respReady = 1'b0;
    logic [31:0] memReadData = 32'h0;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic [29:0] memAddress;
    logic        memReadEn;
    logic        memWriteEn;
    logic [3:0]  memByteEn;
    logic [31:0] memWriteData;

    bus_responder #(.WAIT_STATES(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqSize      (reqSize),
        .reqSigned    (reqSigned),
        .address      (address),
        .writeData    (writeData),
        .respValid    (respValid),
        .respReady    (respReady),
        .respData     (respData),
        .respError    (respError),
        .memAddress   (memAddress),
        .memReadEn    (memReadEn),
        .memWriteEn   (memWriteEn),
        .memByteEn    (memByteEn),
        .memWriteData (memWriteData),
        .memReadData  (memReadData)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_wpulse = 0;
    int exp_pulses = 0;

    // Timeline state shared between the driver and the compare process.
    logic        g_active = 1'b0;
    logic        g_done = 1'b0;
    logic        g_inrst = 1'b1;
    int          g_k = 0;
    logic        e_err = 1'b0;
    logic        e_write = 1'b0;
    logic [3:0]  e_be = 4'h0;
    logic [31:0] e_wd = 32'h0;
    logic [31:0] e_data = 32'h0;
    logic [31:0] e_addr = 32'h0;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected results from the access rules: size in bytes, lane offset, extension.
    function automatic void model(input vec_t v, output logic err, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] data);
        int nb;
        int off;
        logic [63:0] u;
        logic [63:0] lim;
        nb   = 1 << v.sz;
        off  = int'(v.addr[1:0]);
        err  = (v.sz == 2'd3) || ((off % nb) != 0);
        be   = 4'h0;
        wd   = 32'h0;
        data = 32'h0;
        if (!err) begin
            be = 4'(((1 << nb) - 1) << off);
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
            if (!v.wr) begin
                lim = 64'd1 << (8 * nb);
                u   = (64'(v.rdata) >> (8 * off)) & (lim - 64'd1);
                if (v.sg && nb < 4 && u[8*nb-1]) u = u - lim;
                data = u[31:0];
            end
        end
    endfunction

    task automatic chk_reset(input string name);
        chk({name, "_respValid"}, 32'(respValid), 32'd0);
        chk({name, "_respError"}, 32'(respError), 32'd0);
        chk({name, "_respData"}, respData, 32'd0);
        chk({name, "_memReadEn"}, 32'(memReadEn), 32'd0);
        chk({name, "_memWriteEn"}, 32'(memWriteEn), 32'd0);
        chk({name, "_memByteEn"}, 32'(memByteEn), 32'd0);
        chk({name, "_memAddress"}, 32'(memAddress), 32'd0);
        chk({name, "_memWriteData"}, memWriteData, 32'd0);
    endtask

    // Compare process: every cycle, DUT outputs against the expected timeline.
    always @(negedge clk) begin
        if (!g_inrst) begin
            if (!g_active || g_done) begin
                chk("idle_reqReady", 32'(reqReady), 32'd1);
                chk("idle_respValid", 32'(respValid), 32'd0);
                chk("idle_memReadEn", 32'(memReadEn), 32'd0);
                chk("idle_memWriteEn", 32'(memWriteEn), 32'd0);
                chk("idle_memByteEn", 32'(memByteEn), 32'd0);
            end else if (g_k < (e_err ? 1 : int'(W) + 2)) begin
                chk("acc_reqReady", 32'(reqReady), 32'd0);
                chk("acc_respValid", 32'(respValid), 32'd0);
                chk("acc_memReadEn", 32'(memReadEn), 32'(!e_write));
                chk("acc_memWriteEn", 32'(memWriteEn), 32'(e_write && (g_k == int'(W) + 1)));
                chk("acc_memByteEn", 32'(memByteEn), 32'(e_be));
                chk("acc_memAddress", 32'(memAddress), 32'(e_addr[31:2]));
                if (e_write) chk("acc_memWriteData", memWriteData, e_wd);
            end else begin
                chk("rsp_reqReady", 32'(reqReady), 32'd0);
                chk("rsp_respValid", 32'(respValid), 32'd1);
                chk("rsp_respData", respData, e_data);
                chk("rsp_respError", 32'(respError), 32'(e_err));
                chk("rsp_memReadEn", 32'(memReadEn), 32'd0);
                chk("rsp_memWriteEn", 32'(memWriteEn), 32'd0);
                chk("rsp_memByteEn", 32'(memByteEn), 32'd0);
            end
        end
        if (memWriteEn === 1'b1) n_wpulse++;
    end

    task automatic start_req(input vec_t v);
        logic err;
        logic [3:0] be;
        logic [31:0] wd;
        logic [31:0] data;
        model(v, err, be, wd, data);
        @(negedge clk);
        reqValid    = 1'b1;
        reqWrite    = v.wr;
        reqSize     = v.sz;
        reqSigned   = v.sg;
        address     = v.addr;
        writeData   = v.wdata;
        memReadData = v.rdata;
        respReady   = 1'b0;
        e_err       = err;
        e_be        = be;
        e_wd        = wd;
        e_data      = data;
        e_write     = v.wr;
        e_addr      = v.addr;
        @(posedge clk);
        g_active = 1'b1;
        g_done   = 1'b0;
        g_k      = 1;
    endtask

    task automatic run(input vec_t v);
        int lat;
        start_req(v);
        lat = e_err ? 1 : int'(W) + 2;
        if (v.wr && !e_err) exp_pulses++;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (g_k == 1 && !v.x_err) begin
                chk("lit_memByteEn", 32'(memByteEn), 32'(v.x_be));
                if (v.wr) chk("lit_memWriteData", memWriteData, v.x_wd);
            end
            if (g_k == lat) begin
                chk("lit_respData", respData, v.x_data);
                chk("lit_respError", 32'(respError), 32'(v.x_err));
            end
            if (g_k >= lat && (g_k - lat) >= v.hold) begin
                respReady = 1'b1;
                reqValid  = 1'b0;
            end else if (g_k >= lat) begin
                // Competing request while the response is stalled; must be ignored.
                respReady = 1'b0;
                reqValid  = 1'b1;
                address   = 32'h0;
                reqSize   = 2'b10;
                reqWrite  = 1'b1;
                writeData = 32'hFFFF_FFFF;
            end else begin
                respReady = v.early;
                reqValid  = 1'b0;
            end
            @(posedge clk);
            if (g_k >= lat && respReady) begin
                g_done = 1'b1;
                break;
            end
            g_k++;
        end
        chk("handshake_done", 32'(g_done), 32'd1);
        @(negedge clk);
        respReady   = 1'b0;
        reqValid    = 1'b0;
        memReadData = 32'hBAD0_BAD0;
        @(negedge clk);
        g_active = 1'b0;
        g_done   = 1'b0;
    endtask

    initial begin
        //          wr    sz     sg    addr          wdata         rdata      hold early
        //          x_data        x_err x_be  x_wd
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 1'b0,
                     32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0, 1'b0,
                     32'h0, 1'b0, 4'h8, 32'hA5A5_A5A5};
        vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 1'b0,
                     32'hFFFF_8001, 1'b0, 4'hC, 32'h0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 1'b0,
                     32'h0000_8001, 1'b0, 4'hC, 32'h0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 32'hDEAD_BEEF, 0, 1'b0,
                     32'h0, 1'b1, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h0000_1234, 32'h0, 0, 1'b1,
                     32'h0, 1'b0, 4'hC, 32'h1234_1234};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_8000, 0, 1'b0,
                     32'hFFFF_FF80, 1'b0, 4'h2, 32'h0};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, 32'h7F00_0000, 0, 1'b0,
                     32'h0000_007F, 1'b0, 4'h8, 32'h0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0, 0, 1'b0,
                     32'h0, 1'b0, 4'hF, 32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0, 0, 1'b0,
                     32'h0, 1'b1, 4'h0, 32'h0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0000_BEEF, 32'h0, 0, 1'b0,
                     32'h0, 1'b1, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'h0123_4567, 5, 1'b0,
                     32'h0123_4567, 1'b0, 4'hF, 32'h0};
        vecs[12] = '{1'b0, 2'd2, 1'b1, 32'h0000_0008, 32'h0, 32'h8000_0000, 0, 1'b0,
                     32'h8000_0000, 1'b0, 4'hF, 32'h0};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h0000_0000, 32'hFFFF_FF5A, 32'h0, 0, 1'b0,
                     32'h0, 1'b0, 4'h1, 32'h5A5A_5A5A};

        // Power-on reset.
        #12;
        chk_reset("por");
        @(negedge clk);
        reset = 1'b1;
        #1;
        g_inrst = 1'b0;
        chk("por_reqReady", 32'(reqReady), 32'd1);

        for (int i = 0; i < 14; i++) run(vecs[i]);

        // Asynchronous reset in the middle of a store's ACCESS phase (counter=1).
        start_req('{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h0, 0, 1'b0,
                    32'h0, 1'b0, 4'hF, 32'h1122_3344});
        @(negedge clk);
        reqValid = 1'b0;
        @(posedge clk);
        g_k = 2;
        @(negedge clk);
        #2;
        reset    = 1'b0;
        g_inrst  = 1'b1;
        g_active = 1'b0;
        #1;
        chk_reset("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset("rst_hold");
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        g_inrst = 1'b0;
        chk("rst_reqReady", 32'(reqReady), 32'd1);

        // Requests after the aborted store must complete normally.
        run(vecs[0]);
        run(vecs[1]);

        repeat (2) @(negedge clk);
        chk("write_pulses", 32'(n_wpulse), 32'(exp_pulses));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
